// File: rtl/mrelbp_axil_master_pkg.sv
// Shared types and constants for the MRELBP AXI4-Lite host-side master.
package mrelbp_axil_master_pkg;

    // Master FSM states
    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } axil_mst_state_t;

    // AXI response encodings
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // MRELBP control slave register offsets
    localparam logic [31:0] REG_CTRL = 32'h0000_0000;
    localparam logic [31:0] REG_CFG  = 32'h0000_0004;

endpackage

// File: rtl/axil_watchdog.sv
// Loadable saturating cycle counter; expired_o is high during the Limit-th enabled cycle
// since the last load. Limit = 0 disables expiry.
module axil_watchdog #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CntW    = (Limit > 1) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCnt = (Limit == 0) ? '0 : CntW'(Limit - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] count_q;

    // Count enabled cycles, saturating at the last allowed value
    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != LastCnt)) begin
            count_q <= count_q + CntOne;
        end
    end

    assign expired_o = (Limit != 0) && en_i && (count_q == LastCnt);

endmodule

// File: rtl/mrelbp_axil_master.sv
// AXI4-Lite master turning single-word register commands into AXI-Lite transactions
// toward the MRELBP control slave. One command in flight, watchdog-guarded.
module mrelbp_axil_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // command side
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    // response side
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [1:0]          rsp_resp_o,
    output logic                rsp_timeout_o,
    // AXI-Lite write channels
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,
    // AXI-Lite read channels
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o
);

    import mrelbp_axil_master_pkg::*;

    axil_mst_state_t     state_q;
    logic                cmd_ready_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                aw_done_q, w_done_q;
    logic                rsp_valid_q, rsp_timeout_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;

    logic accept;
    logic aw_hs, w_hs, aw_done_n, w_done_n;
    logic wd_en, wd_expired;
    logic abort;

    assign accept    = cmd_ready_q && cmd_valid_i;
    assign aw_hs     = awvalid_q && m_axi_awready_i;
    assign w_hs      = wvalid_q && m_axi_wready_i;
    assign aw_done_n = aw_done_q || aw_hs;
    assign w_done_n  = w_done_q || w_hs;
    assign wd_en     = (state_q == StWrReq) || (state_q == StWrResp) ||
                       (state_q == StRdAddr) || (state_q == StRdData);

    axil_watchdog #(
        .Limit (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Expiry aborts unless the phase completes in the same cycle (a completing handshake wins)
    always_comb begin
        abort = 1'b0;
        case (state_q)
            StWrReq:  abort = wd_expired && !(aw_done_n && w_done_n);
            StWrResp: abort = wd_expired && !m_axi_bvalid_i;
            StRdAddr: abort = wd_expired && !m_axi_arready_i;
            StRdData: abort = wd_expired && !m_axi_rvalid_i;
            default:  abort = 1'b0;
        endcase
    end

    // Transaction FSM with registered channel and response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXI_RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else if (abort) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXI_RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            state_q       <= StDone;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        wstrb_q     <= cmd_wstrb_i;
                        if (cmd_write_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= StWrReq;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdAddr;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StWrReq: begin
                    if (aw_done_n && w_done_n) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWrResp;
                    end else begin
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end
                    end
                end
                StWrResp: begin
                    if (m_axi_bvalid_i) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= m_axi_bresp_i;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StDone;
                    end
                end
                StRdAddr: begin
                    if (m_axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (m_axi_rvalid_i) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= m_axi_rdata_i;
                        rsp_resp_q    <= m_axi_rresp_i;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o     = cmd_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_resp_o      = rsp_resp_q;
    assign rsp_timeout_o   = rsp_timeout_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;

endmodule
